// File: rtl/riscv_crypto_fu_sm4_iter.sv
// riscv_crypto_fu_sm4_iter: multi-cycle SM4 T / T' round-function unit.
// result = rs1 ^ L(tau(rs2)), with SBOX_LANES (1, 2 or 4) S-boxes per cycle.
// The first group of bytes is folded into the accept cycle, so a full word
// needs 4 / SBOX_LANES cycles from accept to out_valid.
// Optional feature macro: RISCV_CRYPTO_SM4_BYTE_MODE_EN enables the
// single-byte (ssm4-compatible) mode selected by op_byte / bs.
module riscv_crypto_fu_sm4_iter #(
    parameter int unsigned SBOX_LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [1:0]  bs,
    input  logic        op_ks,
    input  logic        op_ed,
    input  logic        op_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    // SM4 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SboxTable[2047 - 8 * int'(x) -: 8];
    endfunction

    // Linear layer applied to one zero-extended S-box output (L' when ks).
    function automatic logic [31:0] sm4_lin(input logic [7:0] s8, input logic ks);
        logic [31:0] s;
        s = {24'h0, s8};
        if (ks) begin
            return s ^ ((s & 32'h07) << 29) ^ ((s & 32'hFE) << 7) ^ ((s & 32'h01) << 23)
                     ^ ((s & 32'hF8) << 13);
        end
        return s ^ (s << 8) ^ (s << 2) ^ (s << 18) ^ ((s & 32'h3F) << 26)
                 ^ ((s & 32'hC0) << 10);
    endfunction

    function automatic logic [31:0] rot_bytes(input logic [31:0] c, input logic [1:0] k);
        logic [31:0] r;
        unique case (k)
            2'd0:    r = c;
            2'd1:    r = {c[23:0], c[31:24]};
            2'd2:    r = {c[15:0], c[31:16]};
            default: r = {c[7:0], c[31:8]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_contrib(input logic [31:0] w, input logic ks,
                                                 input logic [1:0] k);
        return rot_bytes(sm4_lin(sbox(w[8 * k +: 8]), ks), k);
    endfunction

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rs2_q, rs2_d;
    logic        ks_q, ks_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        byte_sel;
    logic [1:0]  byte_k;
    logic        unused_inputs;

`ifdef RISCV_CRYPTO_SM4_BYTE_MODE_EN
    // Byte mode completes on the accept cycle, so bs/op_byte need no stored copy.
    assign byte_sel      = op_byte;
    assign byte_k        = bs;
    assign unused_inputs = op_ed;
`else
    assign byte_sel      = 1'b0;
    assign byte_k        = 2'd0;
    assign unused_inputs = ^{bs, op_byte, op_ed};
`endif

    logic [31:0] lane_word;
    logic        lane_ks;
    logic [1:0]  lane_base;
    logic        lane_one;
    logic [31:0] mix;

    // Lane operands: live inputs on the accept cycle, latched copies while busy.
    always_comb begin
        lane_word = rs2_q;
        lane_ks   = ks_q;
        lane_base = cnt_q[1:0];
        lane_one  = 1'b0;
        if (state_q == StIdle) begin
            lane_word = rs2;
            lane_ks   = op_ks;
            lane_base = 2'd0;
            lane_one  = byte_sel;
        end
    end

    // XOR of this cycle's rotated byte contributions.
    always_comb begin
        mix = '0;
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
            if (lane_one) begin
                if (l == 0) mix ^= lane_contrib(lane_word, lane_ks, byte_k);
            end else begin
                mix ^= lane_contrib(lane_word, lane_ks, lane_base + 2'(l));
            end
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle accept.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rs2_d   = rs2_q;
        ks_d    = ks_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        acc_d = rs1 ^ mix;
                        rs2_d = rs2;
                        ks_d  = op_ks;
                        if (byte_sel || SBOX_LANES >= 4) begin
                            state_d = StDone;
                            cnt_d   = '0;
                        end else begin
                            state_d = StBusy;
                            cnt_d   = 3'(SBOX_LANES);
                        end
                    end
                end
                StBusy: begin
                    acc_d = acc_q ^ mix;
                    if (cnt_q + 3'(SBOX_LANES) == 3'd4) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'(SBOX_LANES);
                    end
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            rs2_q   <= '0;
            ks_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rs2_q   <= rs2_d;
            ks_q    <= ks_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = acc_q;

endmodule

// File: tb/tb_riscv_crypto_fu_sm4_iter.sv
// Bench for riscv_crypto_fu_sm4_iter: 1-, 2- and 4-lane builds side by side,
// checked every cycle against a word-level SM4 T-transform model.
module tb_riscv_crypto_fu_sm4_iter;

`ifdef RISCV_CRYPTO_SM4_BYTE_MODE_EN
    localparam bit ByteEn = 1'b1;
`else
    localparam bit ByteEn = 1'b0;
`endif

    localparam logic [2047:0] SboxTab = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    localparam int MIdle = 0;
    localparam int MBusy = 1;
    localparam int MDone = 2;

    logic        clk;
    logic        rst_n;
    logic        flush     [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] rs1       [3];
    logic [31:0] rs2       [3];
    logic [1:0]  bs        [3];
    logic        op_ks     [3];
    logic        op_ed     [3];
    logic        op_byte   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] result    [3];

    // Model state per instance.
    int          m_st    [3];
    int          m_rem   [3];
    logic [31:0] m_res   [3];
    logic        m_known [3];

    logic [31:0] lit_exp [3];
    bit          lit_en  [3];
    int          timeouts;
    bit          done;
    int          n_tests;
    int          n_fail;

    function automatic int lanes_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscv_crypto_fu_sm4_iter #(
            .SBOX_LANES((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .rs1      (rs1[g]),
            .rs2      (rs2[g]),
            .bs       (bs[g]),
            .op_ks    (op_ks[g]),
            .op_ed    (op_ed[g]),
            .op_byte  (op_byte[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .result   (result[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level reference: rs1 xor the rotated contribution of each selected byte.
    function automatic logic [31:0] model_t(input logic [31:0] a, input logic [31:0] b,
                                            input logic ks, input logic byt,
                                            input logic [1:0] sel);
        logic [31:0] acc;
        logic [31:0] s;
        logic [31:0] c;
        logic [63:0] dbl;
        acc = a;
        for (int k = 0; k < 4; k++) begin
            if (!(ByteEn && byt) || k == int'(sel)) begin
                s = {24'h0, SboxTab[2047 - 8 * int'(b[8 * k +: 8]) -: 8]};
                if (ks) c = s ^ ((s & 32'h07) << 29) ^ ((s & 32'hFE) << 7)
                          ^ ((s & 32'h01) << 23) ^ ((s & 32'hF8) << 13);
                else    c = s ^ (s << 8) ^ (s << 2) ^ (s << 18) ^ ((s & 32'h3F) << 26)
                          ^ ((s & 32'hC0) << 10);
                dbl = {c, c} >> (32 - 8 * k);
                acc ^= dbl[31:0];
            end
        end
        return acc;
    endfunction

    function automatic int op_lat(input int i, input logic byt);
        return (ByteEn && byt) ? 1 : 4 / lanes_of(i);
    endfunction

    // Reference timeline: accept, then latency cycles to DONE, then handshake.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_st[i]    <= MIdle;
                m_rem[i]   <= 0;
                m_res[i]   <= '0;
                m_known[i] <= 1'b1;
            end else if (flush[i]) begin
                m_st[i]    <= MIdle;
                m_known[i] <= 1'b0;
            end else begin
                case (m_st[i])
                    MIdle: if (in_valid[i]) begin
                        m_res[i]   <= model_t(rs1[i], rs2[i], op_ks[i], op_byte[i], bs[i]);
                        m_known[i] <= 1'b1;
                        if (op_lat(i, op_byte[i]) == 1) m_st[i] <= MDone;
                        else begin
                            m_st[i]  <= MBusy;
                            m_rem[i] <= op_lat(i, op_byte[i]) - 1;
                        end
                    end
                    MBusy: begin
                        if (m_rem[i] == 1) m_st[i] <= MDone;
                        m_rem[i] <= m_rem[i] - 1;
                    end
                    default: if (out_ready[i]) m_st[i] <= MIdle;
                endcase
            end
        end
    end

    // Single compare process; also owns the summary.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    n_tests += 3;
                    if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || result[i] !== 32'h0)
                    begin
                        n_fail++;
                        $display("FAIL reset[%0d]: got rdy=%b vld=%b res=%h expected 1 0 0",
                                 i, in_ready[i], out_valid[i], result[i]);
                    end
                end else begin
                    n_tests++;
                    if (in_ready[i] !== (m_st[i] == MIdle)) begin
                        n_fail++;
                        $display("FAIL in_ready[%0d] t=%0t: got %b expected %b", i, $time,
                                 in_ready[i], m_st[i] == MIdle);
                    end
                    n_tests++;
                    if (out_valid[i] !== (m_st[i] == MDone)) begin
                        n_fail++;
                        $display("FAIL out_valid[%0d] t=%0t: got %b expected %b", i, $time,
                                 out_valid[i], m_st[i] == MDone);
                    end
                    if (m_st[i] != MBusy && m_known[i]) begin
                        n_tests++;
                        if (result[i] !== m_res[i]) begin
                            n_fail++;
                            $display("FAIL result[%0d] t=%0t: got %h expected %h", i, $time,
                                     result[i], m_res[i]);
                        end
                    end
                    if (m_st[i] == MDone && out_ready[i] && lit_en[i]) begin
                        n_tests++;
                        if (result[i] !== lit_exp[i]) begin
                            n_fail++;
                            $display("FAIL literal[%0d] t=%0t: got %h expected %h", i, $time,
                                     result[i], lit_exp[i]);
                        end
                    end
                end
            end
            if (done) begin
                n_tests++;
                if (timeouts != 0) begin
                    n_fail++;
                    $display("FAIL timeouts: got %0d expected 0", timeouts);
                end
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input int idx);
        int t;
        t = 0;
        while (!in_ready[idx] && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) timeouts++;
    endtask

    // One operation: accept, scramble inputs while busy, optional backpressure.
    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic ks, input logic ed, input logic byt,
                         input logic [1:0] sel, input logic [31:0] lit, input bit lit_on,
                         input int hold);
        int t;
        wait_ready(idx);
        rs1[idx]       = a;
        rs2[idx]       = b;
        op_ks[idx]     = ks;
        op_ed[idx]     = ed;
        op_byte[idx]   = byt;
        bs[idx]        = sel;
        in_valid[idx]  = 1'b1;
        lit_exp[idx]   = lit;
        lit_en[idx]    = lit_on;
        out_ready[idx] = (hold == 0);
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        rs1[idx]      = $urandom;
        rs2[idx]      = $urandom;
        op_ks[idx]    = ~ks;
        bs[idx]       = ~sel;
        t = 0;
        while (!out_valid[idx] && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) timeouts++;
        repeat (hold) @(posedge clk);
        #1 out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        lit_en[idx] = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        timeouts = 0;
        done     = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush[i] = 1'b0; in_valid[i] = 1'b0; rs1[i] = '0; rs2[i] = '0; bs[i] = '0;
            op_ks[i] = 1'b0; op_ed[i] = 1'b0; op_byte[i] = 1'b0; out_ready[i] = 1'b1;
            lit_exp[i] = '0; lit_en[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            issue(i, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h5B5B5B5B, 1'b1, 0);
            issue(i, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h67676767, 1'b1, 0);
            issue(i, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h98989898, 1'b1, 0);
            issue(i, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h67676767, 1'b1, 0);
            issue(i, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h5B5B5B5B, 1'b1, 0);
            issue(i, 32'h0, 32'h01010101, 1'b0, 1'b1, 1'b0, 2'd0, 32'h42424242, 1'b1, 0);
            issue(i, 32'h0, 32'h01010101, 1'b1, 1'b0, 1'b0, 2'd0, 32'hCACACACA, 1'b1, 0);
            issue(i, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd0,
                  ByteEn ? 32'h5B5BD58E : 32'h5B5B5B5B, 1'b1, 0);
            issue(i, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0,
                  ByteEn ? 32'hC01A6BD6 : 32'h67676767, 1'b1, 0);
            issue(i, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd1,
                  ByteEn ? 32'h5BD58E5B : 32'h5B5B5B5B, 1'b1, 0);
            // Backpressure: result held and in_ready low for 5 cycles.
            issue(i, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h5B5B5B5B, 1'b1, 5);
        end

        // Same random operands through every build.
        for (int j = 0; j < 6; j++) begin
            r = $urandom;
            for (int i = 0; i < 3; i++)
                issue(i, r ^ 32'hA5A5_0F0F, r, j[0], 1'b1, j[1], r[1:0], 32'h0, 1'b0, 0);
        end

        // Flush in BUSY on the 1-lane build, with a competing in_valid.
        wait_ready(0);
        rs1[0] = 32'h1234_5678; rs2[0] = 32'h9ABC_DEF0; op_ks[0] = 1'b0; op_byte[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        flush[0] = 1'b1; in_valid[0] = 1'b1; rs2[0] = 32'h0;
        @(posedge clk); #1;
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h67676767, 1'b1, 0);

        // Asynchronous reset in the middle of a 1-lane operation.
        rs1[0] = 32'hDEAD_BEEF; rs2[0] = 32'h0102_0304; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h98989898, 1'b1, 0);

        repeat (2) @(posedge clk);
        #1 done = 1'b1;
    end

endmodule
